regfile_ctrl: RTL and testbench

Write-port arbiter and hazard scoreboard for the 8×16-bit register file. Shares the regfile's single write port (DEST / w_in / w_en) between two writeback requesters, the ALU and the memory/load unit, using round-robin arbitration. Tracks one busy bit per register so decode stalls on RAW and WAW hazards. Sits between decode/issue, the execution units and `regfile`.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 32 +++
 rtl/regfile_ctrl.sv | 104 ++++++++++
 tb/tb_regfile_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared widths, requester ids and writeback request record for the regfile write path.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREG   = 2 ** ADDR_W;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; bit REQ_ALU/REQ_MEM of req_vld/gnt.
// Latency: combinational grant; prio flop updates on the contested edge.
// Backpressure: the loser of a contested cycle wins the next one.
module rr_arbiter2
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_vld,
    output logic [1:0] gnt
);

    req_e prio_q, prio_d;

    always_comb begin
        gnt    = req_vld;
        prio_d = prio_q;
        if (&req_vld) begin
            gnt    = (prio_q == REQ_ALU) ? 2'b01 : 2'b10;
            prio_d = (prio_q == REQ_ALU) ? REQ_MEM : REQ_ALU;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_q <= REQ_ALU;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/regfile_ctrl.sv
// Regfile write-port arbiter (ALU vs load) plus per-register busy scoreboard.
// Latency: grant -> rf_w_en next cycle -> regfile write and busy clear on the edge after.
// Backpressure: issue stalls on RAW/WAW; a contested writeback waits at most one cycle.
module regfile_ctrl
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int NREG   = cpu_pkg::NREG
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_dest,
    input  logic [ADDR_W-1:0] issue_src0,
    input  logic [ADDR_W-1:0] issue_src1,
    output logic              issue_stall,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_dest,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_dest,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic [ADDR_W-1:0] rf_dest,
    output logic [DATA_W-1:0] rf_w_in,
    output logic              rf_w_en,
    output logic [NREG-1:0]   busy,
    output logic              wb_orphan
);

    wb_req_t           alu_req, mem_req, win_req;
    logic [1:0]        gnt;
    logic              issue_accept;

    logic [NREG-1:0]   busy_q, busy_d;
    logic              rf_w_en_q, rf_w_en_d;
    logic [ADDR_W-1:0] rf_dest_q, rf_dest_d;
    logic [DATA_W-1:0] rf_w_in_q, rf_w_in_d;

    assign alu_req = '{valid: alu_valid, dest: alu_dest, data: alu_data};
    assign mem_req = '{valid: mem_valid, dest: mem_dest, data: mem_data};

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_vld ({mem_req.valid, alu_req.valid}),
        .gnt     (gnt)
    );

    assign alu_ready = gnt[REQ_ALU];
    assign mem_ready = gnt[REQ_MEM];

    // A lone valid is always granted, so the selected record's valid is "some grant".
    assign win_req = gnt[REQ_MEM] ? mem_req : alu_req;

    assign issue_stall  = issue_valid &
                          (busy_q[issue_src0] | busy_q[issue_src1] | busy_q[issue_dest]);
    assign issue_accept = issue_valid & ~issue_stall;

    assign wb_orphan = rf_w_en_q & ~busy_q[rf_dest_q];

    always_comb begin
        rf_w_en_d = win_req.valid;
        rf_dest_d = rf_dest_q;
        rf_w_in_d = rf_w_in_q;
        if (win_req.valid) begin
            rf_dest_d = win_req.dest;
            rf_w_in_d = win_req.data;
        end
    end

    // Clear and set never hit the same bit: issue to a busy dest stalls.
    always_comb begin
        busy_d = busy_q;
        if (rf_w_en_q) begin
            busy_d[rf_dest_q] = 1'b0;
        end
        if (issue_accept) begin
            busy_d[issue_dest] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q    <= '0;
            rf_w_en_q <= 1'b0;
            rf_dest_q <= '0;
            rf_w_in_q <= '0;
        end else begin
            busy_q    <= busy_d;
            rf_w_en_q <= rf_w_en_d;
            rf_dest_q <= rf_dest_d;
            rf_w_in_q <= rf_w_in_d;
        end
    end

    assign busy    = busy_q;
    assign rf_w_en = rf_w_en_q;
    assign rf_dest = rf_dest_q;
    assign rf_w_in = rf_w_in_q;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl: per-cycle vector table plus a mid-write reset sequence.
module tb_regfile_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [2:0]  issue_dest, issue_src0, issue_src1;
    logic        issue_stall;
    logic        alu_valid;
    logic [2:0]  alu_dest;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [2:0]  mem_dest;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic [2:0]  rf_dest;
    logic [15:0] rf_w_in;
    logic        rf_w_en;
    logic [7:0]  busy;
    logic        wb_orphan;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_dest  (issue_dest),
        .issue_src0  (issue_src0),
        .issue_src1  (issue_src1),
        .issue_stall (issue_stall),
        .alu_valid   (alu_valid),
        .alu_dest    (alu_dest),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_dest    (mem_dest),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .rf_dest     (rf_dest),
        .rf_w_in     (rf_w_in),
        .rf_w_en     (rf_w_en),
        .busy        (busy),
        .wb_orphan   (wb_orphan)
    );

    typedef struct {
        logic        iv;
        logic [2:0]  id, is0, is1;
        logic        av;
        logic [2:0]  ad;
        logic [15:0] adat;
        logic        mv;
        logic [2:0]  md;
        logic [15:0] mdat;
        logic        stall, ar, mr, wen;
        logic [2:0]  rdest;
        logic [15:0] rwin;
        logic [7:0]  busy;
        logic        orph;
    } vec_t;

    function automatic vec_t mk(
        input logic iv, input logic [2:0] id, input logic [2:0] is0, input logic [2:0] is1,
        input logic av, input logic [2:0] ad, input logic [15:0] adat,
        input logic mv, input logic [2:0] md, input logic [15:0] mdat,
        input logic stall, input logic ar, input logic mr, input logic wen,
        input logic [2:0] rdest, input logic [15:0] rwin, input logic [7:0] bsy,
        input logic orph);
        vec_t v;
        v.iv = iv; v.id = id; v.is0 = is0; v.is1 = is1;
        v.av = av; v.ad = ad; v.adat = adat;
        v.mv = mv; v.md = md; v.mdat = mdat;
        v.stall = stall; v.ar = ar; v.mr = mr; v.wen = wen;
        v.rdest = rdest; v.rwin = rwin; v.busy = bsy; v.orph = orph;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        issue_valid = v.iv; issue_dest = v.id; issue_src0 = v.is0; issue_src1 = v.is1;
        alu_valid = v.av; alu_dest = v.ad; alu_data = v.adat;
        mem_valid = v.mv; mem_dest = v.md; mem_data = v.mdat;
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        chk({tag, ".stall"}, 16'(issue_stall), 16'(v.stall));
        chk({tag, ".alu_ready"}, 16'(alu_ready), 16'(v.ar));
        chk({tag, ".mem_ready"}, 16'(mem_ready), 16'(v.mr));
        chk({tag, ".rf_w_en"}, 16'(rf_w_en), 16'(v.wen));
        chk({tag, ".rf_dest"}, 16'(rf_dest), 16'(v.rdest));
        chk({tag, ".rf_w_in"}, rf_w_in, v.rwin);
        chk({tag, ".busy"}, 16'(busy), 16'(v.busy));
        chk({tag, ".orphan"}, 16'(wb_orphan), 16'(v.orph));
    endtask

    vec_t tbl[20];
    vec_t v;

    initial begin
        //            iv id s0 s1  av ad adat      mv md mdat     st ar mr we rd rwin      busy   or
        tbl[0]  = mk(0, 0, 0, 0,  0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 0);
        tbl[1]  = mk(1, 3, 1, 2,  0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 0);
        tbl[2]  = mk(1, 4, 3, 0,  1, 3, 16'hAAAA, 0, 0, 16'h0000, 1, 1, 0, 0, 0, 16'h0000, 8'h08, 0);
        tbl[3]  = mk(1, 4, 3, 0,  0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 1, 3, 16'hAAAA, 8'h08, 0);
        tbl[4]  = mk(1, 4, 3, 0,  0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 3, 16'hAAAA, 8'h00, 0);
        tbl[5]  = mk(1, 1, 0, 0,  0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 3, 16'hAAAA, 8'h10, 0);
        tbl[6]  = mk(1, 2, 0, 0,  0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 3, 16'hAAAA, 8'h12, 0);
        tbl[7]  = mk(0, 0, 0, 0,  1, 1, 16'hBBBB, 1, 2, 16'hCCCC, 0, 1, 0, 0, 3, 16'hAAAA, 8'h16, 0);
        tbl[8]  = mk(0, 0, 0, 0,  1, 1, 16'h1111, 1, 2, 16'hCCCC, 0, 0, 1, 1, 1, 16'hBBBB, 8'h16, 0);
        tbl[9]  = mk(0, 0, 0, 0,  1, 1, 16'h1111, 1, 2, 16'h2222, 0, 1, 0, 1, 2, 16'hCCCC, 8'h14, 0);
        tbl[10] = mk(0, 0, 0, 0,  0, 0, 16'h0000, 1, 2, 16'h2222, 0, 0, 1, 1, 1, 16'h1111, 8'h10, 1);
        tbl[11] = mk(0, 0, 0, 0,  0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 1, 2, 16'h2222, 8'h10, 1);
        tbl[12] = mk(0, 0, 0, 0,  0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 2, 16'h2222, 8'h10, 0);
        tbl[13] = mk(1, 5, 0, 0,  0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 2, 16'h2222, 8'h10, 0);
        tbl[14] = mk(1, 5, 0, 0,  0, 0, 16'h0000, 1, 5, 16'h5555, 1, 0, 1, 0, 2, 16'h2222, 8'h30, 0);
        tbl[15] = mk(1, 5, 0, 0,  0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 1, 5, 16'h5555, 8'h30, 0);
        tbl[16] = mk(1, 5, 0, 0,  0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 5, 16'h5555, 8'h10, 0);
        tbl[17] = mk(0, 0, 0, 0,  0, 0, 16'h0000, 1, 6, 16'hFFFF, 0, 0, 1, 0, 5, 16'h5555, 8'h30, 0);
        tbl[18] = mk(0, 0, 0, 0,  0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 1, 6, 16'hFFFF, 8'h30, 1);
        tbl[19] = mk(0, 0, 0, 0,  0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 6, 16'hFFFF, 8'h30, 0);

        // Reset state, with an issue presenting every source as register 7.
        reset = 1'b0;
        drive(mk(1, 7, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check_vec("rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 0));
        @(negedge clk);
        drive(tbl[0]);
        reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            check_vec($sformatf("v%0d", i), tbl[i]);
        end

        // Here prio points at MEM and busy = 0x30. Build busy = 0x14 with a write in flight.
        @(negedge clk);
        drive(mk(1, 2, 0, 0, 1, 4, 16'h4444, 1, 5, 16'h5556, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("h1.mem_ready", 16'(mem_ready), 16'h1);
        chk("h1.alu_ready", 16'(alu_ready), 16'h0);
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 1, 4, 16'h4444, 1, 2, 16'h2223, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("h2.alu_ready", 16'(alu_ready), 16'h1);
        chk("h2.rf_dest", 16'(rf_dest), 16'h5);
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("h3.rf_w_en", 16'(rf_w_en), 16'h1);
        chk("h3.rf_w_in", rf_w_in, 16'h4444);
        chk("h3.busy", 16'(busy), 16'h14);

        // Asynchronous reset in the middle of the write cycle.
        #1 reset = 1'b0;
        #1;
        chk("ar.rf_w_en", 16'(rf_w_en), 16'h0);
        chk("ar.busy", 16'(busy), 16'h00);
        chk("ar.rf_dest", 16'(rf_dest), 16'h0);
        chk("ar.rf_w_in", rf_w_in, 16'h0000);
        drive(mk(1, 4, 4, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("ar.stall", 16'(issue_stall), 16'h0);
        chk("ar.orphan", 16'(wb_orphan), 16'h0);
        @(posedge clk);
        #1;
        chk("ar_hold.rf_w_en", 16'(rf_w_en), 16'h0);
        chk("ar_hold.busy", 16'(busy), 16'h00);

        // First contested grant after release must go to the ALU.
        @(negedge clk);
        reset = 1'b1;
        drive(mk(0, 0, 0, 0, 1, 7, 16'h7777, 1, 6, 16'h6666, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("post.alu_ready", 16'(alu_ready), 16'h1);
        chk("post.mem_ready", 16'(mem_ready), 16'h0);
        @(posedge clk);
        #1;
        chk("post.rf_w_en", 16'(rf_w_en), 16'h1);
        chk("post.rf_dest", 16'(rf_dest), 16'h7);
        chk("post.rf_w_in", rf_w_in, 16'h7777);

        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
